// File: rtl/tensor_core_issue_scheduler.sv
// -----------------------------------------------------------------------------
// tensor_core_issue_scheduler
//
// Sits directly in front of the cpu. It buffers the host instruction stream in a
// small FIFO and issues one instruction per cycle on current_instruction_out.
//
// When a TENSOR_CORE_OPERATE (opcode 8'h05) is issued, issue stops and NOPs are
// presented until the tensor core raises done. This keeps tensor-core register
// writes from colliding with the MMA result write-back. If done never arrives
// within OPERATE_TIMEOUT wait cycles, issue resumes and a sticky error is raised.
//
// Parameters
//   FIFO_DEPTH       instruction FIFO entries (power of 2, >= 2)
//   OPERATE_TIMEOUT  maximum wait cycles before the timeout error (>= 2)
//
// Ports
//   clock_in                 system clock (same clock as the cpu)
//   reset_n_in               asynchronous, active-low reset
//   host_instruction_in      instruction word from the host
//   host_valid_in            host_instruction_in is valid
//   host_ready_out           FIFO can accept a word (count < FIFO_DEPTH)
//   tensor_core_done_in      tensor core finished its calculation
//   current_instruction_out  registered instruction to the cpu
//   busy_out                 waiting for the tensor core
//   fifo_count_out           occupied FIFO entries
//   timeout_error_out        sticky: an OPERATE timed out (cleared by reset only)
//
// Optional build macro SCHED_PERF_COUNTERS_EN adds:
//   issued_count_out[15:0]   non-NOP instructions popped (wraps)
//   stall_count_out[15:0]    cycles spent waiting for the tensor core (wraps)
// -----------------------------------------------------------------------------
module tensor_core_issue_scheduler #(
  parameter int FIFO_DEPTH      = 4,
  parameter int OPERATE_TIMEOUT = 16
) (
  input  logic                        clock_in,
  input  logic                        reset_n_in,
  input  logic [31:0]                 host_instruction_in,
  input  logic                        host_valid_in,
  output logic                        host_ready_out,
  input  logic                        tensor_core_done_in,
  output logic [31:0]                 current_instruction_out,
  output logic                        busy_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_out,
  output logic                        timeout_error_out
`ifdef SCHED_PERF_COUNTERS_EN
  ,
  output logic [15:0]                 issued_count_out,
  output logic [15:0]                 stall_count_out
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(OPERATE_TIMEOUT);

  localparam logic [AW:0]   FULL_COUNT     = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] TIMEOUT_LAST   = CW'(OPERATE_TIMEOUT - 1);
  localparam logic [31:0]   NOP_WORD       = 32'h0000_0008;
  localparam logic [7:0]    OPCODE_OPERATE = 8'h05;

  localparam logic [0:0] ST_ISSUE   = 1'b0;
  localparam logic [0:0] ST_WAIT_TC = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] tc_cnt;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   head;
  logic          push;
  logic          pop;

  // Ready depends only on the registered count, so a full FIFO refuses a word
  // even on a cycle where it is also popping.
  assign host_ready_out = (fifo_count_out < FULL_COUNT);
  assign push           = host_valid_in & host_ready_out;
  assign pop            = (state == ST_ISSUE) && (fifo_count_out != '0);
  assign head           = mem[rd_ptr];
  assign busy_out       = (state == ST_WAIT_TC);

  // NOTE: the storage array has no reset; an entry is only read after it has
  // been written, and leaving it out keeps the array mappable to plain RAM.
  always_ff @(posedge clock_in) begin
    if (push) begin
      mem[wr_ptr] <= host_instruction_in;
    end
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count_out <= '0;
    end else begin
      // Pointers are exactly log2(depth) bits wide, so they wrap naturally.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count_out <= fifo_count_out + (AW+1)'(1);
        2'b01:   fifo_count_out <= fifo_count_out - (AW+1)'(1);
        default: fifo_count_out <= fifo_count_out;
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state                   <= ST_ISSUE;
      tc_cnt                  <= '0;
      current_instruction_out <= NOP_WORD;
      timeout_error_out       <= 1'b0;
    end else begin
      case (state)
        ST_ISSUE: begin
          if (pop) begin
            current_instruction_out <= head;
            // The OPERATE word itself is shown for exactly this one cycle.
            if (head[7:0] == OPCODE_OPERATE) begin
              state  <= ST_WAIT_TC;
              tc_cnt <= '0;
            end
          end else begin
            current_instruction_out <= NOP_WORD;
          end
        end
        ST_WAIT_TC: begin
          current_instruction_out <= NOP_WORD;
          tc_cnt                  <= tc_cnt + CW'(1);
          // done takes priority, so a done on the final wait cycle is not an error.
          if (tensor_core_done_in) begin
            state <= ST_ISSUE;
          end else if (tc_cnt == TIMEOUT_LAST) begin
            state             <= ST_ISSUE;
            timeout_error_out <= 1'b1;
          end
        end
        default: begin
          state                   <= ST_ISSUE;
          current_instruction_out <= NOP_WORD;
        end
      endcase
    end
  end

`ifdef SCHED_PERF_COUNTERS_EN
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      issued_count_out <= '0;
      stall_count_out  <= '0;
    end else begin
      if (pop && (head != NOP_WORD)) issued_count_out <= issued_count_out + 16'd1;
      if (state == ST_WAIT_TC)       stall_count_out  <= stall_count_out + 16'd1;
    end
  end
`endif

endmodule
